// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD types and helpers for the scanned BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles saturate to 9 so a bad load never leaves an illegal digit.
    function automatic bcd_digit_t bcd_clamp(bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control/data bundle between the counter and whatever drives it and reads the display bus.
interface bcd_scan_counter_if #(
    parameter int NDIG = 2
);
    logic                en;
    logic                up;
    logic                load;
    logic [4*NDIG-1:0]   load_val;
    logic [4*NDIG-1:0]   count;
    logic [0:3]          bcd_out;
    logic [NDIG-1:0]     dig_sel;
    logic                tc;

    modport master (
        output en, up, load, load_val,
        input  count, bcd_out, dig_sel, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output count, bcd_out, dig_sel, tc
    );
endinterface

// File: rtl/bcd_scan_counter_cell.sv
// One decade of the counter; carry/borrow out feeds the step of the next decade.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t ld_val,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       co
);

    assign co = step && (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(ld_val);
        end else if (step) begin
            if (up)
                digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
            else
                digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaler and load, plus a digit scanner that
// time-multiplexes the decades onto one bit-reversed BCD bus with active-low digit select.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int NDIG     = 2,
    parameter int PRESCALE = 50_000_000,
    parameter int SCAN_DIV = 50_000
)(
    input logic               clk,
    input logic               rst,
    bcd_scan_counter_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [PW-1:0]               pre;
    logic                        tick;
    logic [NDIG:0]               carry;
    logic [NDIG-1:0][3:0]        digits;
    logic                        tc_q;

    logic [SW-1:0]               scan_tmr;
    logic [IW-1:0]               scan_idx;
    logic [IW-1:0]               idx_nxt;
    logic [NDIG-1:0]             dsel_q;
    logic [NDIG-1:0]             dsel_nxt;
    bcd_digit_t                  cur_digit;
    logic [0:3]                  bcd_q;
    logic [0:3]                  bcd_nxt;

    // ---------------- prescaler / count chain ----------------
    assign tick = bus.en && (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            pre <= '0;
        else if (bus.load)
            pre <= '0;
        else if (bus.en)
            pre <= tick ? '0 : pre + 1'b1;
    end

    assign carry[0] = tick;

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .load   (bus.load),
            .ld_val (bus.load_val[4*k +: 4]),
            .step   (carry[k]),
            .up     (bus.up),
            .digit  (digits[k]),
            .co     (carry[k+1])
        );
    end

    // Carry out of the top decade on a real tick is exactly the wrap event.
    always_ff @(posedge clk) begin
        if (rst)
            tc_q <= 1'b0;
        else
            tc_q <= tick && !bus.load && carry[NDIG];
    end

    // ---------------- digit scanner ----------------
    always_ff @(posedge clk) begin
        if (rst)
            scan_tmr <= '0;
        else
            scan_tmr <= (scan_tmr == SCAN_LAST) ? '0 : scan_tmr + 1'b1;
    end

    always_comb begin
        idx_nxt = scan_idx;
        if (scan_tmr == SCAN_LAST)
            idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end

    // Select and data both derive from idx_nxt so they always flip on the same edge.
    always_comb begin
        dsel_nxt  = ~(NDIG'(1) << idx_nxt);
        cur_digit = digits[idx_nxt];
        bcd_nxt   = '0;
        for (int i = 0; i < 4; i++)
            bcd_nxt[i] = cur_digit[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= '0;
            dsel_q   <= ~NDIG'(1);
            bcd_q    <= '0;
        end else begin
            scan_idx <= idx_nxt;
            dsel_q   <= dsel_nxt;
            bcd_q    <= bcd_nxt;
        end
    end

    assign bus.count   = digits;
    assign bus.tc      = tc_q;
    assign bus.dig_sel = dsel_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: a decimal reference model pushes expected outputs each cycle, popped after the edge.
module tb_bcd_scan_counter;

    localparam int NDIG     = 2;
    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic [1:0] dsel;
        logic [3:0] bcd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_scan_counter_if #(.NDIG(NDIG)) bus();

    bcd_scan_counter #(
        .NDIG     (NDIG),
        .PRESCALE (PRESCALE),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    int   m_cnt, m_pre, m_tmr, m_idx;
    logic m_tc;
    int   tcs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int from_load(input logic [7:0] lv);
        int hi, lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    // Bus bit 0 (leftmost of [0:3]) carries weight 1.
    function automatic logic [3:0] rev4(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    task automatic cyc();
        exp_t       e;
        int         old;
        int         d;
        logic       tick;
        logic [1:0] one;
        logic [3:0] dn;
        one = 2'b01;
        old = m_cnt;
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_tmr = 0; m_idx = 0; m_tc = 1'b0;
            e.bcd = 4'b0000;
        end else begin
            tick = bus.en && (m_pre == PRESCALE - 1);
            m_tc = 1'b0;
            if (bus.load) begin
                m_cnt = from_load(bus.load_val);
                m_pre = 0;
            end else if (bus.en) begin
                m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    if (bus.up) begin
                        m_tc  = (m_cnt == 99);
                        m_cnt = (m_cnt + 1) % 100;
                    end else begin
                        m_tc  = (m_cnt == 0);
                        m_cnt = (m_cnt + 99) % 100;
                    end
                end
            end
            if (m_tmr == SCAN_DIV - 1) begin
                m_tmr = 0;
                m_idx = (m_idx + 1) % NDIG;
            end else begin
                m_tmr++;
            end
            d     = (m_idx == 0) ? old % 10 : old / 10;
            dn    = 4'(d);
            e.bcd = rev4(dn);
        end
        e.cnt  = to_bcd(m_cnt);
        e.tc   = m_tc;
        e.dsel = ~(one << m_idx);
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("count",   32'(bus.count),   32'(e.cnt));
        chk("tc",      32'(bus.tc),      32'(e.tc));
        chk("dig_sel", 32'(bus.dig_sel), 32'(e.dsel));
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
        if (bus.tc === 1'b1) tcs++;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        m_cnt = 0; m_pre = 0; m_tmr = 0; m_idx = 0; m_tc = 1'b0; tcs = 0;

        // reset state
        cyc(); cyc();
        chk("rst_count", 32'(bus.count), 32'h00);
        chk("rst_dsel",  32'(bus.dig_sel), 32'b10);
        rst = 1'b0;

        // 1: free-running up count, 10 ticks in 40 clk
        bus.en = 1'b1; bus.up = 1'b1;
        tcs = 0;
        repeat (40) cyc();
        chk("t1_count", 32'(bus.count), 32'h10);
        chk("t1_tc_pulses", 32'(tcs), 32'd0);

        // 2: wrap 99 -> 00
        bus.load = 1'b1; bus.load_val = 8'h98;
        cyc();
        bus.load = 1'b0;
        tcs = 0;
        repeat (11) cyc();
        chk("t2_count", 32'(bus.count), 32'h00);
        chk("t2_tc_pulses", 32'(tcs), 32'd1);

        // 3: down wrap 00 -> 99, then 98
        bus.up = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'h00;
        cyc();
        bus.load = 1'b0;
        tcs = 0;
        repeat (11) cyc();
        chk("t3_count", 32'(bus.count), 32'h98);
        chk("t3_tc_pulses", 32'(tcs), 32'd1);

        // 4: clamped load, then load colliding with a tick
        bus.en = 1'b0; bus.up = 1'b1;
        bus.load = 1'b1; bus.load_val = 8'hF3;
        cyc();
        chk("t4_clamp", 32'(bus.count), 32'h93);
        bus.en = 1'b1; bus.load_val = 8'h20;
        cyc();
        bus.load = 1'b0;
        repeat (3) cyc();
        bus.load = 1'b1; bus.load_val = 8'h45;
        cyc();
        chk("t4_ld_tick_count", 32'(bus.count), 32'h45);
        chk("t4_ld_tick_tc",    32'(bus.tc), 32'd0);
        bus.load = 1'b0;

        // 5: scanning a held 57
        bus.en = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'h57;
        cyc();
        bus.load = 1'b0;
        repeat (2) cyc();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.dig_sel == 2'b10) chk("t5_bcd_d0", 32'(bus.bcd_out), 32'b1110);
            else                      chk("t5_bcd_d1", 32'(bus.bcd_out), 32'b1010);
        end

        // 6: reset mid-count / mid-scan, then en=0 hold
        bus.en = 1'b1; bus.up = 1'b1;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        chk("t6_rst_count", 32'(bus.count),   32'h00);
        chk("t6_rst_dsel",  32'(bus.dig_sel), 32'b10);
        chk("t6_rst_bcd",   32'(bus.bcd_out), 32'b0000);
        chk("t6_rst_tc",    32'(bus.tc),      32'd0);
        rst = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'h31;
        cyc();
        bus.load = 1'b0;
        repeat (20) cyc();
        chk("t6_hold", 32'(bus.count), 32'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
